// File: rtl/ethernet_pkg.sv
// Shared Ethernet receive constants and types, plus the reflected CRC32 byte update
// used by the receive engine's FCS checker.
package ethernet_pkg;

  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam int          MIN_FRAME_BYTES = 64;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY      = 32'hEDB8_8320;
  // Register value left after running a frame plus its own FCS through the CRC.
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;

  typedef struct packed {
    logic oversize;
    logic runt;
    logic align;
    logic phy_err;
    logic crc_err;
  } eth_rx_status_t;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    FRAME,
    DISCARD,
    END
  } eth_rx_xmii_states_t;

  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ethernet_crc32.sv
// Byte-wide Ethernet CRC32 register: initialise to all-ones, fold in one byte per
// compute strobe, LSB-first.
module ethernet_crc32
  import ethernet_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        initialize_i,
  input  logic        compute_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc32_o
);

  logic [31:0] r_crc;

  // NOTE: clocked state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_crc <= CRC32_INIT;
    end else if (initialize_i) begin
      r_crc <= CRC32_INIT;
    end else if (compute_i) begin
      r_crc <= crc32_next(r_crc, data_i);
    end
  end

  assign crc32_o = r_crc;

endmodule

// File: rtl/ethernet_rx_xmii.sv
// Ethernet MAC receive engine for RMII/MII/GMII symbols: SFD hunt, destination
// filter, FCS residue check, 4-byte FCS strip via a 5-entry delay line, status and counters.
module ethernet_rx_xmii
  import ethernet_pkg::*;
#(
  parameter int          DATA_WIDTH      = 2,
  parameter logic [47:0] MAC_ADDRESS     = 48'h00_00_00_00_00_00,
  parameter int          MAX_FRAME_BYTES = 1522
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  sample_i,
  input  logic                  enable_i,
  input  logic                  promiscuous_i,
  input  logic                  accept_multicast_i,
  input  logic [DATA_WIDTH-1:0] rxd_i,
  input  logic                  rx_dv_i,
  input  logic                  rx_er_i,
  output logic [7:0]            data_o,
  output logic                  valid_o,
  output logic                  last_o,
  output logic                  error_o,
  output logic                  status_valid_o,
  output logic [4:0]            status_o,
  output logic [10:0]           frame_length_o,
  output logic [15:0]           good_count_o,
  output logic [15:0]           drop_count_o
);

  localparam int          DL_DEPTH      = 5;
  localparam int          SYMS_PER_BYTE = 8 / DATA_WIDTH;
  localparam logic [1:0]  SYM_LAST      = 2'(SYMS_PER_BYTE - 1);
  localparam logic [10:0] LEN_MAX       = 11'h7FF;
  localparam logic [15:0] CNT_MAX       = 16'hFFFF;

  eth_rx_xmii_states_t r_state, w_state_next;

  logic [7:0]     r_shift, w_shift_next;
  logic [1:0]     r_sym_cnt;
  logic [10:0]    r_byte_cnt;
  logic [2:0]     r_dl_count;
  logic [7:0]     r_dl [DL_DEPTH];
  logic           r_phy_err;
  logic [7:0]     r_data;
  logic           r_valid, r_last, r_error, r_status_valid;
  eth_rx_status_t r_status, w_status;
  logic [10:0]    r_frame_length;
  logic [15:0]    r_good_count, r_drop_count;

  logic           w_byte_done, w_accept, w_reject, w_emit;
  logic [47:0]    w_dest;
  logic [31:0]    w_crc;

  // The same register is the preamble window and the byte assembler.
  if (DATA_WIDTH == 8) begin : g_shift_full
    assign w_shift_next = rxd_i;
  end else begin : g_shift_part
    assign w_shift_next = {rxd_i, r_shift[7:DATA_WIDTH]};
  end

  assign w_byte_done = sample_i && rx_dv_i && (r_state == FRAME) && (r_sym_cnt == SYM_LAST);

  // The sixth byte completes the destination; it and the filter decision arrive together.
  assign w_dest   = {r_dl[0], r_dl[1], r_dl[2], r_dl[3], r_dl[4], w_shift_next};
  assign w_accept = promiscuous_i || (w_dest == MAC_ADDRESS) || (&w_dest)
                    || (accept_multicast_i && r_dl[0][0]);
  assign w_reject = w_byte_done && (r_byte_cnt == 11'd5) && !w_accept;
  assign w_emit   = w_byte_done && (r_dl_count == 3'(DL_DEPTH)) && !w_reject;

  ethernet_crc32 u_crc32 (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .initialize_i (r_state == IDLE),
    .compute_i    (w_byte_done),
    .data_i       (w_shift_next),
    .crc32_o      (w_crc)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_status         = '0;
    w_status.oversize = r_byte_cnt > 11'(MAX_FRAME_BYTES);
    w_status.runt     = r_byte_cnt < 11'(MIN_FRAME_BYTES);
    w_status.align    = r_sym_cnt != 2'd0;
    w_status.phy_err  = r_phy_err;
    w_status.crc_err  = w_crc != CRC32_RESIDUE;
    unique case (r_state)
      IDLE:     if (sample_i && rx_dv_i && enable_i) w_state_next = PREAMBLE;
      PREAMBLE: if (sample_i) begin
                  if (!rx_dv_i || rx_er_i)          w_state_next = IDLE;
                  else if (w_shift_next == SFD_BYTE) w_state_next = FRAME;
                end
      FRAME:    if (sample_i) begin
                  if (!rx_dv_i)     w_state_next = END;
                  else if (w_reject) w_state_next = DISCARD;
                end
      DISCARD:  if (sample_i && !rx_dv_i) w_state_next = IDLE;
      END:      w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_shift        <= '0;
      r_sym_cnt      <= '0;
      r_byte_cnt     <= '0;
      r_dl_count     <= '0;
      r_phy_err      <= 1'b0;
      r_data         <= '0;
      r_valid        <= 1'b0;
      r_last         <= 1'b0;
      r_error        <= 1'b0;
      r_status_valid <= 1'b0;
      r_status       <= '0;
      r_frame_length <= '0;
      r_good_count   <= '0;
      r_drop_count   <= '0;
    end else begin
      r_valid        <= 1'b0;
      r_last         <= 1'b0;
      r_error        <= 1'b0;
      r_status_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_shift    <= '0;
          r_sym_cnt  <= '0;
          r_byte_cnt <= '0;
          r_dl_count <= '0;
          r_phy_err  <= 1'b0;
        end
        PREAMBLE: if (sample_i) begin
          r_shift   <= w_shift_next;
          r_sym_cnt <= '0;
        end
        FRAME: if (sample_i) begin
          if (rx_er_i) r_phy_err <= 1'b1;
          if (rx_dv_i) begin
            r_shift   <= w_shift_next;
            r_sym_cnt <= (r_sym_cnt == SYM_LAST) ? 2'd0 : r_sym_cnt + 2'd1;
          end
          if (w_byte_done) begin
            if (r_byte_cnt != LEN_MAX) r_byte_cnt <= r_byte_cnt + 11'd1;
            if (r_dl_count != 3'(DL_DEPTH)) r_dl_count <= r_dl_count + 3'd1;
          end
          if (w_emit) begin
            r_data  <= r_dl[0];
            r_valid <= 1'b1;
          end
        end
        DISCARD: if (sample_i && !rx_dv_i && r_drop_count != CNT_MAX) begin
          r_drop_count <= r_drop_count + 16'd1;
        end
        END: begin
          r_status_valid <= 1'b1;
          r_status       <= w_status;
          r_frame_length <= r_byte_cnt;
          // Fewer than six bytes never passed the filter, so nothing is delivered.
          if (r_byte_cnt >= 11'd6) begin
            r_data  <= r_dl[0];
            r_valid <= 1'b1;
            r_last  <= 1'b1;
            r_error <= (w_status != '0);
          end
          if (w_status == '0) begin
            if (r_good_count != CNT_MAX) r_good_count <= r_good_count + 16'd1;
          end else if (r_drop_count != CNT_MAX) begin
            r_drop_count <= r_drop_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: delay-line storage has no reset; r_dl_count alone says which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_byte_done) begin
      if (r_dl_count == 3'(DL_DEPTH)) begin
        for (int i = 0; i < DL_DEPTH - 1; i++) r_dl[i] <= r_dl[i+1];
        r_dl[DL_DEPTH-1] <= w_shift_next;
      end else begin
        for (int i = 0; i < DL_DEPTH; i++) begin
          if (r_dl_count == 3'(i)) r_dl[i] <= w_shift_next;
        end
      end
    end
  end

  assign data_o         = r_data;
  assign valid_o        = r_valid;
  assign last_o         = r_last;
  assign error_o        = r_error;
  assign status_valid_o = r_status_valid;
  assign status_o       = r_status;
  assign frame_length_o = r_frame_length;
  assign good_count_o   = r_good_count;
  assign drop_count_o   = r_drop_count;

endmodule

// File: tb/tb_ethernet_rx_xmii.sv
// Scoreboard bench: the same frames are fed in lockstep to RMII, MII and GMII
// instances; expected bytes and status are queued when frames are built.
module tb_ethernet_rx_xmii;

  localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;
  localparam int          GAP = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] err;
  } exp_byte_t;

  typedef struct packed {
    logic [2:0][4:0] st;
    logic [10:0]     len;
  } exp_stat_t;

  logic clk = 1'b0;
  logic rst_n, en, promisc, amc, dv, er;
  logic [2:0] smp;
  logic [1:0] rxd2;
  logic [3:0] rxd4;
  logic [7:0] rxd8;

  logic [7:0]  dat  [3];
  logic        val  [3];
  logic        lst  [3];
  logic        erro [3];
  logic        sv   [3];
  logic [4:0]  st   [3];
  logic [10:0] flen [3];
  logic [15:0] gc   [3];
  logic [15:0] dc   [3];

  exp_byte_t exp_b[$];
  exp_stat_t exp_s[$];
  int rd_b[3], rd_s[3], good_e[3], drop_e[3];
  int last_len;
  int n_cmp = 0, n_err = 0;
  int cyc = 0, fall_cyc = 0;
  bit mon_off = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ethernet_rx_xmii #(.DATA_WIDTH(2), .MAC_ADDRESS(MAC), .MAX_FRAME_BYTES(1522)) u_dut_w2 (
    .clk_i(clk), .rst_n_i(rst_n), .sample_i(smp[0]), .enable_i(en), .promiscuous_i(promisc),
    .accept_multicast_i(amc), .rxd_i(rxd2), .rx_dv_i(dv), .rx_er_i(er),
    .data_o(dat[0]), .valid_o(val[0]), .last_o(lst[0]), .error_o(erro[0]),
    .status_valid_o(sv[0]), .status_o(st[0]), .frame_length_o(flen[0]),
    .good_count_o(gc[0]), .drop_count_o(dc[0]));

  ethernet_rx_xmii #(.DATA_WIDTH(4), .MAC_ADDRESS(MAC), .MAX_FRAME_BYTES(1522)) u_dut_w4 (
    .clk_i(clk), .rst_n_i(rst_n), .sample_i(smp[1]), .enable_i(en), .promiscuous_i(promisc),
    .accept_multicast_i(amc), .rxd_i(rxd4), .rx_dv_i(dv), .rx_er_i(er),
    .data_o(dat[1]), .valid_o(val[1]), .last_o(lst[1]), .error_o(erro[1]),
    .status_valid_o(sv[1]), .status_o(st[1]), .frame_length_o(flen[1]),
    .good_count_o(gc[1]), .drop_count_o(dc[1]));

  ethernet_rx_xmii #(.DATA_WIDTH(8), .MAC_ADDRESS(MAC), .MAX_FRAME_BYTES(1522)) u_dut_w8 (
    .clk_i(clk), .rst_n_i(rst_n), .sample_i(smp[2]), .enable_i(en), .promiscuous_i(promisc),
    .accept_multicast_i(amc), .rxd_i(rxd8), .rx_dv_i(dv), .rx_er_i(er),
    .data_o(dat[2]), .valid_o(val[2]), .last_o(lst[2]), .error_o(erro[2]),
    .status_valid_o(sv[2]), .status_o(st[2]), .frame_length_o(flen[2]),
    .good_count_o(gc[2]), .drop_count_o(dc[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Output monitor: every delivered byte and status pulse is matched against the queues.
  always @(negedge clk) begin
    if (!mon_off) begin
      for (int l = 0; l < 3; l++) begin
        if (val[l]) begin
          if (rd_b[l] < exp_b.size()) begin
            check($sformatf("L%0d_data%0d", l, rd_b[l]), dat[l], exp_b[rd_b[l]].data);
            check($sformatf("L%0d_last%0d", l, rd_b[l]), lst[l], exp_b[rd_b[l]].last);
            if (lst[l]) check($sformatf("L%0d_error", l), erro[l], exp_b[rd_b[l]].err[l]);
            rd_b[l]++;
          end else begin
            check($sformatf("L%0d_unexpected_valid", l), 1, 0);
          end
        end
        if (sv[l]) begin
          if (rd_s[l] < exp_s.size()) begin
            check($sformatf("L%0d_status", l), st[l], exp_s[rd_s[l]].st[l]);
            check($sformatf("L%0d_frame_length", l), flen[l], exp_s[rd_s[l]].len);
            rd_s[l]++;
          end else begin
            check($sformatf("L%0d_unexpected_status", l), 1, 0);
          end
        end
      end
      if (val[2] && lst[2]) check("w8_last_latency_le2", (cyc - fall_cyc) <= 2, 1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic e);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      dv   = 1'b1;
      er   = e;
      smp  = {s == 0, s < 2, 1'b1};
      rxd2 = b[2*s +: 2];
      if (s < 2) rxd4 = b[4*s +: 4];
      rxd8 = b;
    end
  endtask

  task automatic send_preamble();
    repeat (7) send_byte(8'h55, 1'b0);
    send_byte(8'hD5, 1'b0);
  endtask

  task automatic end_frame();
    @(negedge clk);
    dv = 1'b0; er = 1'b0; smp = 3'b111;
    fall_cyc = cyc;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic check_tallies(input string tag);
    for (int l = 0; l < 3; l++) begin
      check($sformatf("%s_L%0d_good", tag, l), gc[l], good_e[l]);
      check($sformatf("%s_L%0d_drop", tag, l), dc[l], drop_e[l]);
      check($sformatf("%s_L%0d_bytes_seen", tag, l), rd_b[l], exp_b.size());
      check($sformatf("%s_L%0d_status_seen", tag, l), rd_s[l], exp_s.size());
      check($sformatf("%s_L%0d_len_hold", tag, l), flen[l], last_len);
    end
  endtask

  task automatic run_frame(input string tag, input logic [47:0] dst, input int len, input bit bad,
                           input int er_at, input bit odd, input int en_off_at, input bit disabled);
    logic [7:0] f[$];
    logic [31:0] c;
    bit acc;
    exp_byte_t eb;
    exp_stat_t es;
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(8'h10 + 8'(i));
    f.push_back(8'h08);
    f.push_back(8'h00);
    for (int i = 0; i < len - 18; i++) f.push_back(8'($urandom_range(0, 255)));
    c = 32'hFFFF_FFFF;
    foreach (f[i]) c = crc_upd(c, f[i]);
    c = ~c;
    f.push_back(c[7:0]); f.push_back(c[15:8]); f.push_back(c[23:16]); f.push_back(c[31:24]);
    if (bad) f[len-2] = f[len-2] ^ 8'h08;

    acc = promisc || (dst == MAC) || (&dst) || (amc && dst[40]);
    for (int l = 0; l < 3; l++) es.st[l] = {len > 1522, len < 64, odd && (l == 0), er_at >= 0, bad};
    es.len = 11'(len);
    if (!disabled) begin
      if (acc) begin
        for (int i = 0; i <= len - 5; i++) begin
          eb.data = f[i];
          eb.last = (i == len - 5);
          for (int l = 0; l < 3; l++) eb.err[l] = (es.st[l] != 0);
          exp_b.push_back(eb);
        end
        exp_s.push_back(es);
        last_len = len;
        for (int l = 0; l < 3; l++) begin
          if (es.st[l] == 0) good_e[l]++;
          else               drop_e[l]++;
        end
      end else begin
        for (int l = 0; l < 3; l++) drop_e[l]++;
      end
    end

    en = !disabled;
    send_preamble();
    for (int i = 0; i < len; i++) begin
      if (i == en_off_at) en = 1'b0;
      send_byte(f[i], i == er_at);
    end
    if (odd) begin
      @(negedge clk);
      dv = 1'b1; er = 1'b0; smp = 3'b001; rxd2 = 2'b10;
    end
    end_frame();
    en = 1'b1;
    check_tallies(tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int l = 0; l < 3; l++) begin
      check($sformatf("%s_L%0d_valid", tag, l), val[l], 0);
      check($sformatf("%s_L%0d_last", tag, l), lst[l], 0);
      check($sformatf("%s_L%0d_error", tag, l), erro[l], 0);
      check($sformatf("%s_L%0d_sv", tag, l), sv[l], 0);
      check($sformatf("%s_L%0d_status", tag, l), st[l], 0);
      check($sformatf("%s_L%0d_flen", tag, l), flen[l], 0);
      check($sformatf("%s_L%0d_data", tag, l), dat[l], 0);
      check($sformatf("%s_L%0d_good", tag, l), gc[l], 0);
      check($sformatf("%s_L%0d_drop", tag, l), dc[l], 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; promisc = 1'b0; amc = 1'b0;
    dv = 1'b0; er = 1'b0; smp = 3'b000; rxd2 = '0; rxd4 = '0; rxd8 = '0;
    last_len = 0;
    for (int l = 0; l < 3; l++) begin
      rd_b[l] = 0; rd_s[l] = 0; good_e[l] = 0; drop_e[l] = 0;
    end
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    mon_off = 1'b0;
    repeat (4) @(negedge clk);

    run_frame("bcast64", 48'hFFFF_FFFF_FFFF, 64, 0, -1, 0, -1, 0);
    run_frame("reject", 48'h02_00_00_00_00_01, 64, 0, -1, 0, -1, 0);
    promisc = 1'b1;
    run_frame("promisc", 48'h02_00_00_00_00_01, 64, 0, -1, 0, -1, 0);
    promisc = 1'b0;
    amc = 1'b1;
    run_frame("mcast", 48'h01_00_5E_00_00_FB, 66, 0, -1, 0, -1, 0);
    amc = 1'b0;
    run_frame("mcast_off", 48'h01_00_5E_00_00_FB, 64, 0, -1, 0, -1, 0);
    run_frame("unicast", MAC, 70, 0, -1, 0, -1, 0);
    run_frame("bad_fcs", 48'hFFFF_FFFF_FFFF, 64, 1, -1, 0, -1, 0);
    run_frame("runt40", 48'hFFFF_FFFF_FFFF, 40, 0, -1, 0, -1, 0);
    run_frame("oversize", 48'hFFFF_FFFF_FFFF, 1600, 0, -1, 0, -1, 0);
    run_frame("phy_err", 48'hFFFF_FFFF_FFFF, 64, 0, 20, 0, -1, 0);
    run_frame("odd_dibit", 48'hFFFF_FFFF_FFFF, 64, 0, -1, 1, -1, 0);
    run_frame("disabled", 48'hFFFF_FFFF_FFFF, 64, 0, -1, 0, -1, 1);
    run_frame("en_drop_mid", MAC, 80, 0, -1, 0, 30, 0);

    // Reset in the middle of a payload: all outputs must clear on the next edge.
    mon_off = 1'b1;
    send_preamble();
    for (int i = 0; i < 30; i++) send_byte((i < 6) ? 8'hFF : 8'(i), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("mid_reset");
    rst_n = 1'b1; dv = 1'b0;
    repeat (GAP) @(negedge clk);
    exp_b.delete(); exp_s.delete();
    last_len = 0;
    for (int l = 0; l < 3; l++) begin
      rd_b[l] = 0; rd_s[l] = 0; good_e[l] = 0; drop_e[l] = 0;
    end
    mon_off = 1'b0;
    run_frame("after_reset", 48'hFFFF_FFFF_FFFF, 64, 0, -1, 0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ethernet_rx_xmii.md
Name: ethernet_rx_xmii

Overview:
- Parametrised Ethernet MAC receive engine for RMII (2-bit), MII (4-bit) and GMII (8-bit) PHY data paths.
- Hunts the preamble for the SFD and filters frames by destination address (unicast, broadcast, multicast, promiscuous).
- Checks the FCS using the CRC32 residue method and flags runt, oversize, misaligned and PHY-error frames.
- Sits between the PHY shim and the RX FIFO. It streams destination-through-payload bytes (FCS stripped), with last/error on the final byte, plus per-frame status and saturating counters.

Parameters:
- DATA_WIDTH, 2, symbol width per sample_i; legal values 2, 4, 8; LSB-first.
- MAC_ADDRESS, 48'h00_00_00_00_00_00, station unicast address, byte 0 first on the wire.
- MAX_FRAME_BYTES, 1522, largest legal frame, destination through FCS.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset; active-low, synchronous
- sample_i  in  1  qualifies rxd_i/rx_dv_i/rx_er_i for this cycle
- enable_i  in  1  receiver enable
- promiscuous_i  in  1  accept every destination address
- accept_multicast_i  in  1  accept group addresses (first destination byte bit0 = 1)
- rxd_i  in  DATA_WIDTH  PHY receive symbol
- rx_dv_i  in  1  data valid; CRS_DV toggling is already resolved by the shim
- rx_er_i  in  1  PHY receive error
- data_o  out  8  frame byte
- valid_o  out  1  data_o valid, one cycle per byte
- last_o  out  1  final byte of frame, with valid_o
- error_o  out  1  frame has any status error, with last_o
- status_valid_o  out  1  one-cycle pulse at end of every frame reaching FRAME
- status_o  out  5  {oversize, runt, align, phy_err, crc_err}
- frame_length_o  out  11  byte count including FCS, saturating at 2047
- good_count_o  out  16  frames delivered without error, saturating
- drop_count_o  out  16  frames filtered or erroneous, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, delay line empty, CRC initialised.
- All datapath updates happen only on sample_i cycles. The symbol assembler shifts rxd_i in LSB-first. A byte completes every 8/DATA_WIDTH samples.
- IDLE: CRC init; byte and symbol counters cleared. rx_dv_i & enable_i → PREAMBLE.
- PREAMBLE: an 8-bit sliding window shifts each sample.
  - Window == 8'hD5 → FRAME, symbol counter 0. This aligns any DATA_WIDTH.
  - rx_dv_i low → IDLE, no status pulse.
- FRAME, per completed byte:
  - CRC compute, byte counter +1, byte pushed into a 5-entry delay line.
  - On completion of byte 5, the filter is evaluated: accept if destination == MAC_ADDRESS, all-ones, (bit0 & accept_multicast_i), or promiscuous_i. Reject → DISCARD.
  - When the delay line is full and a new byte arrives, the oldest byte is emitted (valid_o=1, registered, one cycle after the completing sample).
- FRAME end: rx_dv_i low on a sample → END.
- END, single cycle:
  - If byte count ≥ 6, emit the oldest delay-line entry with last_o=1 and error_o=|status. The remaining 4 entries are the FCS and are discarded.
  - If byte count < 6, nothing is emitted.
  - status_valid_o=1. Update good or drop counter. → IDLE.
- DISCARD: no output. rx_dv_i low → drop_count+1, no status pulse → IDLE.
- Status bits:
  - crc_err: CRC register after the FCS ≠ CRC32_RESIDUE.
  - runt: length < 64.
  - oversize: length > MAX_FRAME_BYTES. Bytes are still emitted; they are not truncated.
  - align: symbol counter ≠ 0 at END.
  - phy_err: any sampled rx_er_i in FRAME.
- enable_i low mid-frame: the current frame completes normally; no new frame starts.
- rx_er_i in PREAMBLE → IDLE.
- Counters saturate at 16'hFFFF. frame_length_o holds its value until the next END.

Decomposition:
- ethernet_pkg gains:
  - SFD_BYTE = 8'hD5
  - MIN_FRAME_BYTES = 64
  - CRC32_RESIDUE = 32'hDEBB20E3 (uninverted register value)
  - packed struct eth_rx_status_t {oversize, runt, align, phy_err, crc_err}
  - enum eth_rx_xmii_states_t {IDLE, PREAMBLE, FRAME, DISCARD, END}
- Sub-module: the existing ethernet_crc32 (initialize_i, compute_i, data_i, crc32_o) as one instance. The delay line and filter stay inline.

Test Plan:
- DATA_WIDTH=2, 7×0x55+0xD5, then a 64-byte broadcast frame with valid FCS → 60 bytes out; last_o on byte 60; error_o=0; status_o=0; frame_length_o=64; good_count_o=1.
- DATA_WIDTH=4 and 8, same frame → identical byte stream and status; for DATA_WIDTH=8, last_o occurs at most 2 cycles after rx_dv_i falls.
- Destination 02:00:00:00:00:01 ≠ MAC_ADDRESS, promiscuous_i=0 → no valid_o, no status_valid_o, drop_count_o=1. Repeat with promiscuous_i=1 → frame delivered.
- 64-byte frame with one FCS bit flipped → last_o with error_o=1, status_o=5'b00001, drop_count_o+1.
- 40-byte frame with good CRC → status_o runt bit=1. 1600-byte frame → oversize=1, all 1596 bytes emitted.
- rx_er_i pulsed at byte 20 → phy_err=1. Frame ending after odd dibit count (RMII) → align=1. rst_n_i low mid-payload → all outputs 0 next cycle, IDLE.
